// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
//   fetch_state_t : Fetch (request outstanding), Hold (fetched word buffered
//                   while stalled), Drop (waiting to discard a stale ack).
//   INST_BYTES    : PC increment between sequential instructions.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DROP  = 2'd2
    } fetch_state_t;

    localparam int unsigned INST_BYTES = 4;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory read bus between the fetch unit and instruction memory.
//   inst_mem_rd_en  : read request (fetch unit -> memory)
//   inst_mem_addr   : request address, stable while rd_en=1 until ack
//   inst_mem_ack    : read data valid this cycle (memory -> fetch unit)
//   inst_mem_rd_dat : read data
// master = fetch unit side, slave = memory side.
interface fetch_unit_if #(
    parameter int DATA_SIZE = 32
);
    logic                 inst_mem_rd_en;
    logic [DATA_SIZE-1:0] inst_mem_addr;
    logic                 inst_mem_ack;
    logic [DATA_SIZE-1:0] inst_mem_rd_dat;

    modport master (
        output inst_mem_rd_en,
        output inst_mem_addr,
        input  inst_mem_ack,
        input  inst_mem_rd_dat
    );

    modport slave (
        input  inst_mem_rd_en,
        input  inst_mem_addr,
        output inst_mem_ack,
        output inst_mem_rd_dat
    );
endinterface

// File: rtl/fetch_unit_if_id_register.sv
// IF/ID pipeline register.
//   clock, reset_n : clock and asynchronous active-low reset
//   load           : a new instruction is delivered this cycle
//   hold           : keep all outputs unchanged
//   clear          : invalidate the outputs (highest priority)
//   pc_in, inst_in : delivered PC and instruction word
//   pc, inst, valid: registered IF/ID outputs
// Priority: clear > hold > load > bubble (valid drops, data kept).
module if_id_register #(
    parameter int DATA_SIZE = 32
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 load,
    input  logic                 hold,
    input  logic                 clear,
    input  logic [DATA_SIZE-1:0] pc_in,
    input  logic [DATA_SIZE-1:0] inst_in,
    output logic [DATA_SIZE-1:0] pc,
    output logic [DATA_SIZE-1:0] inst,
    output logic                 valid
);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc    <= '0;
            inst  <= '0;
            valid <= 1'b0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (hold) begin
            valid <= valid;
        end else if (load) begin
            pc    <= pc_in;
            inst  <= inst_in;
            valid <= 1'b1;
        end else begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues sequential reads to instruction memory,
// buffers a fetched word while the front end is stalled, and follows
// redirects, discarding the data of any request made stale by a redirect.
//   clock, reset_n  : clock and asynchronous active-low reset
//   stall_if        : hold the PC, deliver nothing new
//   stall_id        : hold the IF/ID outputs
//   flush_id        : invalidate the IF/ID outputs
//   redirect_en/pc  : taken branch / jump / trap target from a later stage
//   mem             : instruction memory read bus (master side)
//   pc_id, inst_id, valid_id : IF/ID register outputs
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                   DATA_SIZE = 32,
    parameter logic [DATA_SIZE-1:0] RESET_PC  = '0
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 stall_if,
    input  logic                 stall_id,
    input  logic                 flush_id,
    input  logic                 redirect_en,
    input  logic [DATA_SIZE-1:0] redirect_pc,
    fetch_unit_if.master         mem,
    output logic [DATA_SIZE-1:0] pc_id,
    output logic [DATA_SIZE-1:0] inst_id,
    output logic                 valid_id
);

    localparam logic [DATA_SIZE-1:0] PC_STEP = DATA_SIZE'(INST_BYTES);

    fetch_state_t         state, state_next;
    logic [DATA_SIZE-1:0] pc, pc_next;
    logic [DATA_SIZE-1:0] pending_pc, pending_next;
    logic [DATA_SIZE-1:0] buffer, buffer_next;
    logic                 deliver;
    logic [DATA_SIZE-1:0] deliver_inst;

    // The request stays up in Drop so the stale ack can be consumed;
    // the address is the PC register, so it only moves on an ack.
    assign mem.inst_mem_rd_en = (state != HOLD);
    assign mem.inst_mem_addr  = pc;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            pending_pc <= '0;
            buffer     <= '0;
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            pending_pc <= pending_next;
            buffer     <= buffer_next;
        end
    end

    always_comb begin
        state_next   = state;
        pc_next      = pc;
        pending_next = pending_pc;
        buffer_next  = buffer;
        deliver      = 1'b0;
        deliver_inst = mem.inst_mem_rd_dat;
        unique case (state)
            FETCH: begin
                if (mem.inst_mem_ack) begin
                    if (redirect_en) begin
                        pc_next = redirect_pc;
                    end else if (stall_if) begin
                        buffer_next = mem.inst_mem_rd_dat;
                        state_next  = HOLD;
                    end else begin
                        deliver = 1'b1;
                        pc_next = pc + PC_STEP;
                    end
                end else if (redirect_en) begin
                    // Request already issued: remember the target and
                    // swallow the ack of the now-stale request first.
                    pending_next = redirect_pc;
                    state_next   = DROP;
                end
            end
            HOLD: begin
                if (redirect_en) begin
                    pc_next    = redirect_pc;
                    state_next = FETCH;
                end else if (!stall_if) begin
                    deliver      = 1'b1;
                    deliver_inst = buffer;
                    pc_next      = pc + PC_STEP;
                    state_next   = FETCH;
                end
            end
            DROP: begin
                if (redirect_en) begin
                    pending_next = redirect_pc;
                end
                if (mem.inst_mem_ack) begin
                    // A redirect in the same cycle as the ack is the newest.
                    pc_next    = redirect_en ? redirect_pc : pending_pc;
                    state_next = FETCH;
                end
            end
            default: begin
                state_next = FETCH;
            end
        endcase
    end

    if_id_register #(
        .DATA_SIZE(DATA_SIZE)
    ) u_if_id (
        .clock   (clock),
        .reset_n (reset_n),
        .load    (deliver),
        .hold    (stall_id),
        .clear   (flush_id),
        .pc_in   (pc),
        .inst_in (deliver_inst),
        .pc      (pc_id),
        .inst    (inst_id),
        .valid   (valid_id)
    );

endmodule
